// File: rtl/ring_pkg.sv
// Shared definitions for the one-hot ring-counter interface (counter and decoder side).
// Ring helpers work on a zero-extended word so any width up to RING_MAX_W can share them.
package ring_pkg;

    localparam int unsigned RING_MAX_W = 32;

    typedef logic [RING_MAX_W-1:0] ring_word_t;

    localparam ring_word_t RING_ZERO = {RING_MAX_W{1'b0}};
    localparam ring_word_t RING_ONE  = {{(RING_MAX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } ring_dec_state_e;

    // Legal ring word: all-zero or exactly one bit set.
    function automatic logic is_legal_ring(input ring_word_t word);
        return ((word & (word - RING_ONE)) == RING_ZERO);
    endfunction

    // Successor of a legal word in an n-bit ring; the LSB-hot word shifts out to all-zero.
    function automatic ring_word_t next_ring(input ring_word_t word, input int unsigned n);
        ring_word_t nxt;
        if (word == RING_ZERO) begin
            nxt = RING_ONE << (n - 32'd1);
        end else begin
            nxt = word >> 5'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// Combinational one-hot to index encoder; MSB-hot maps to index 0.
// OR-based (no priority), so the index is forced to zero unless the input is exactly one-hot.
module onehot_to_idx #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          onehot
);

    localparam logic [N-1:0] VEC_ONE = N'(1);

    logic [IW-1:0] acc_s;
    logic          multi_s;

    // Encode by OR-ing the index of every set bit, then qualify with the one-hot flag.
    always_comb begin
        acc_s = IW'(0);
        for (int i = 0; i < N; i++) begin
            acc_s = acc_s | ({IW{vec[N-1-i]}} & IW'(i));
        end
        multi_s = ((vec & (vec - VEC_ONE)) != N'(0));
        onehot  = (vec != N'(0)) && !multi_s;
        idx     = onehot ? acc_s : IW'(0);
    end

endmodule

// File: rtl/ring_seq_decoder.sv
// Ring-counter receive side: decodes the sampled ring word, tracks lock on the legal
// sequence, counts completed revolutions and flags sequence errors.
module ring_seq_decoder
    import ring_pkg::*;
#(
    parameter int N        = 4,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [N-1:0]         q_in,
    input  logic                 clr_err,
    output logic [$clog2(N)-1:0] idx,
    output logic                 idx_valid,
    output logic                 locked,
    output logic                 seq_err,
    output logic                 err_sticky,
    output logic [CNT_W-1:0]     rev_cnt
);

    localparam int IW    = $clog2(N);
    localparam int ACQ_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    localparam logic [ACQ_W-1:0] ACQ_ZERO = ACQ_W'(0);
    localparam logic [ACQ_W-1:0] ACQ_ONE  = ACQ_W'(1);
    localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(LOCK_CNT - 1);
    localparam logic [N-1:0]     LSB_HOT  = N'(1);
    localparam logic [N-1:0]     N_ZERO   = N'(0);
    localparam logic [CNT_W-1:0] REV_ONE  = CNT_W'(1);

    ring_dec_state_e  state_r, state_nx_s;
    logic [N-1:0]     prev_r, prev_nx_s;
    logic [ACQ_W-1:0] acq_cnt_r, acq_nx_s;
    logic [CNT_W-1:0] rev_nx_s;
    logic [IW-1:0]    idx_nx_s, enc_idx_s;
    logic             valid_nx_s, enc_onehot_s;
    logic             err_nx_s, sticky_nx_s;

    ring_word_t       q_ext_s, prev_ext_s;
    logic             legal_s, match_s, wrap_s;

    assign q_ext_s    = {{(RING_MAX_W-N){1'b0}}, q_in};
    assign prev_ext_s = {{(RING_MAX_W-N){1'b0}}, prev_r};
    assign legal_s    = is_legal_ring(q_ext_s);
    assign match_s    = (q_ext_s == next_ring(prev_ext_s, N));
    assign wrap_s     = (prev_r == LSB_HOT) && (q_in == N_ZERO);

    onehot_to_idx #(.N(N), .IW(IW)) u_enc (
        .vec    (q_in),
        .idx    (enc_idx_s),
        .onehot (enc_onehot_s)
    );

    // Next-state, sequence tracking and output computation; everything holds while en=0.
    always_comb begin
        state_nx_s = state_r;
        prev_nx_s  = prev_r;
        acq_nx_s   = acq_cnt_r;
        rev_nx_s   = rev_cnt;
        idx_nx_s   = idx;
        valid_nx_s = idx_valid;
        err_nx_s   = 1'b0;
        if (en) begin
            idx_nx_s   = enc_idx_s;
            valid_nx_s = enc_onehot_s;
            case (state_r)
                ST_SEARCH: begin
                    if (legal_s) begin
                        prev_nx_s  = q_in;
                        acq_nx_s   = ACQ_ZERO;
                        state_nx_s = ST_ACQUIRE;
                    end else begin
                        err_nx_s = 1'b1;
                    end
                end
                ST_ACQUIRE, ST_LOCKED: begin
                    if (match_s) begin
                        prev_nx_s = q_in;
                        if (state_r == ST_LOCKED) begin
                            rev_nx_s = wrap_s ? (rev_cnt + REV_ONE) : rev_cnt;
                        end else if (acq_cnt_r == ACQ_LAST) begin
                            state_nx_s = ST_LOCKED;
                        end else begin
                            acq_nx_s = acq_cnt_r + ACQ_ONE;
                        end
                    end else begin
                        // A repeated word lands here too: the ring must advance every strobe.
                        err_nx_s = 1'b1;
                        if (legal_s) begin
                            prev_nx_s  = q_in;
                            acq_nx_s   = ACQ_ZERO;
                            state_nx_s = ST_ACQUIRE;
                        end else begin
                            state_nx_s = ST_SEARCH;
                        end
                    end
                end
                default: begin
                    state_nx_s = ST_SEARCH;
                end
            endcase
        end else begin
            err_nx_s = 1'b0;
        end
        sticky_nx_s = err_nx_s | (err_sticky & ~clr_err);
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_r <= ST_SEARCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Sequence tracking and registered outputs.
    always_ff @(posedge Clk) begin
        if (reset) begin
            prev_r     <= N_ZERO;
            acq_cnt_r  <= ACQ_ZERO;
            idx        <= IW'(0);
            idx_valid  <= 1'b0;
            locked     <= 1'b0;
            seq_err    <= 1'b0;
            err_sticky <= 1'b0;
            rev_cnt    <= CNT_W'(0);
        end else begin
            prev_r     <= prev_nx_s;
            acq_cnt_r  <= acq_nx_s;
            idx        <= idx_nx_s;
            idx_valid  <= valid_nx_s;
            locked     <= (state_nx_s == ST_LOCKED);
            seq_err    <= err_nx_s;
            err_sticky <= sticky_nx_s;
            rev_cnt    <= rev_nx_s;
        end
    end

endmodule

// File: tb/tb_ring_seq_decoder.sv
// Directed bench for ring_seq_decoder (N=4, LOCK_CNT=2) with an 8-bit and a 2-bit
// revolution counter instance driven by the same stimulus.
module tb_ring_seq_decoder;

    logic       Clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] q_in;
    logic       clr_err;

    logic [1:0] idx, idx2;
    logic       idx_valid, locked, seq_err, err_sticky;
    logic       idx_valid2, locked2, seq_err2, err_sticky2;
    logic [7:0] rev_cnt;
    logic [1:0] rev_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    ring_seq_decoder #(.N(4), .CNT_W(8), .LOCK_CNT(2)) u_dut (
        .Clk(Clk), .reset(reset), .en(en), .q_in(q_in), .clr_err(clr_err),
        .idx(idx), .idx_valid(idx_valid), .locked(locked), .seq_err(seq_err),
        .err_sticky(err_sticky), .rev_cnt(rev_cnt)
    );

    ring_seq_decoder #(.N(4), .CNT_W(2), .LOCK_CNT(2)) u_dut2 (
        .Clk(Clk), .reset(reset), .en(en), .q_in(q_in), .clr_err(clr_err),
        .idx(idx2), .idx_valid(idx_valid2), .locked(locked2), .seq_err(seq_err2),
        .err_sticky(err_sticky2), .rev_cnt(rev_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic e, input logic [3:0] q, input logic c);
        reset   = r;
        en      = e;
        q_in    = q;
        clr_err = c;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int e_idx, input int e_v, input int e_lk,
                             input int e_se, input int e_st, input int e_rev);
        chk({tag, ".idx"},        32'(idx),        32'(e_idx));
        chk({tag, ".idx_valid"},  32'(idx_valid),  32'(e_v));
        chk({tag, ".locked"},     32'(locked),     32'(e_lk));
        chk({tag, ".seq_err"},    32'(seq_err),    32'(e_se));
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(e_st));
        chk({tag, ".rev_cnt"},    32'(rev_cnt),    32'(e_rev % 256));
        chk({tag, ".rev_cnt2"},   32'(rev_cnt2),   32'(e_rev % 4));
        chk({tag, ".locked2"},    32'(locked2),    32'(e_lk));
    endtask

    initial begin
        // Reset dominates an illegal sample with en=1
        step(1'b1, 1'b1, 4'b1111, 1'b0);
        check_all("reset", 0, 0, 0, 0, 0, 0);

        // 1: acquire and lock on a clean revolution
        step(1'b0, 1'b1, 4'b0000, 1'b0); check_all("t1.s0", 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b1, 4'b1000, 1'b0); check_all("t1.s1", 0, 1, 0, 0, 0, 0);
        step(1'b0, 1'b1, 4'b0100, 1'b0); check_all("t1.s2", 1, 1, 1, 0, 0, 0);
        step(1'b0, 1'b1, 4'b0010, 1'b0); check_all("t1.s3", 2, 1, 1, 0, 0, 0);
        step(1'b0, 1'b1, 4'b0001, 1'b0); check_all("t1.s4", 3, 1, 1, 0, 0, 0);
        step(1'b0, 1'b1, 4'b0000, 1'b0); check_all("t1.s5", 0, 0, 1, 0, 0, 1);

        // 2: en=0 holds everything, q_in ignored
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'b1111, 1'b0);
            check_all("t2.hold", 0, 0, 1, 0, 0, 1);
        end

        // 3: skipped position -> error, reacquire from the new word
        step(1'b0, 1'b1, 4'b1000, 1'b0); check_all("t3.s0", 0, 1, 1, 0, 0, 1);
        step(1'b0, 1'b1, 4'b0010, 1'b0); check_all("t3.err", 2, 1, 0, 1, 1, 1);
        step(1'b0, 1'b1, 4'b0001, 1'b0); check_all("t3.s2", 3, 1, 0, 0, 1, 1);
        step(1'b0, 1'b1, 4'b0000, 1'b0); check_all("t3.relock", 0, 0, 1, 0, 1, 1);

        // 4: multi-hot word -> SEARCH, then relock
        step(1'b0, 1'b1, 4'b1100, 1'b0); check_all("t4.err", 0, 0, 0, 1, 1, 1);
        step(1'b0, 1'b1, 4'b0100, 1'b0); check_all("t4.s1", 1, 1, 0, 0, 1, 1);
        step(1'b0, 1'b1, 4'b0010, 1'b0); check_all("t4.s2", 2, 1, 0, 0, 1, 1);
        step(1'b0, 1'b1, 4'b0001, 1'b0); check_all("t4.relock", 3, 1, 1, 0, 1, 1);

        // 5: set beats clear; clear alone drops the sticky flag
        step(1'b0, 1'b1, 4'b0100, 1'b1); check_all("t5.setwins", 1, 1, 0, 1, 1, 1);
        step(1'b0, 1'b1, 4'b0010, 1'b1); check_all("t5.clear", 2, 1, 0, 0, 0, 1);
        step(1'b0, 1'b1, 4'b0001, 1'b0); check_all("t5.relock", 3, 1, 1, 0, 0, 1);

        // 6: revolution counting and wrap of the 2-bit counter, then reset while locked
        step(1'b1, 1'b0, 4'b0000, 1'b0); check_all("t6.reset", 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b1, 4'b0000, 1'b0); check_all("t6.s0", 0, 0, 0, 0, 0, 0);
        for (int r = 1; r <= 7; r++) begin
            step(1'b0, 1'b1, 4'b1000, 1'b0);
            step(1'b0, 1'b1, 4'b0100, 1'b0);
            step(1'b0, 1'b1, 4'b0010, 1'b0);
            step(1'b0, 1'b1, 4'b0001, 1'b0);
            step(1'b0, 1'b1, 4'b0000, 1'b0);
            check_all("t6.rev", 0, 0, 1, 0, 0, r);
        end
        chk("t6.rev2_is3", 32'(rev_cnt2), 32'd3);
        step(1'b1, 1'b1, 4'b1000, 1'b0); check_all("t6.rst_locked", 0, 0, 0, 0, 0, 0);
        // After reset the FSM is in SEARCH: an illegal word errors, a repeated word does not
        step(1'b0, 1'b1, 4'b0110, 1'b0); check_all("t6.search_err", 0, 0, 0, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
